// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/clear, plus a one-shot
// LSB-first serializer with busy/done status.
module univ_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] pout,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_SER   = 3'b110;
  localparam logic [2:0] M_CLR   = 3'b111;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    pout_d  = pout_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          case (mode)
            M_HOLD: pout_d = pout_q;
            M_LOAD: pout_d = pin;
            M_SHL:  pout_d = {pout_q[WIDTH-2:0], sin_r};
            M_SHR:  pout_d = {sin_l, pout_q[WIDTH-1:1]};
            M_ROL:  pout_d = {pout_q[WIDTH-2:0], pout_q[WIDTH-1]};
            M_ROR:  pout_d = {pout_q[0], pout_q[WIDTH-1:1]};
            M_SER: begin
              pout_d  = pin;
              count_d = '0;
              busy_d  = 1'b1;
              state_d = SHIFT;
            end
            M_CLR:  pout_d = '0;
            default: pout_d = pout_q;
          endcase
        end
      end
      default: begin
        // SHIFT: mode and pin are ignored; en=0 stalls the serializer.
        if (en) begin
          pout_d = {sin_l, pout_q[WIDTH-1:1]};
          if (count_q == CW'(WIDTH - 1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pout_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pout_q  <= pout_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pout   = pout_q;
  assign sout_l = pout_q[WIDTH-1];
  assign sout_r = pout_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
